// File: rtl/exe_stage.sv
// exe_stage: execute stage; holds the decode-to-execute register, drives the ALU and issues data-SRAM requests.
// Latency: ALU ops leave after one cycle in stage; multiply ops present their result on the third cycle.
// Backpressure: ms_allowin low holds the register and all outputs; the SRAM request fires only in the departure cycle.
// Build option: define EXE_MUL_EN to compile in the two-cycle multiplier (M_IDLE/M_CALC/M_DONE).
module exe_stage #(
  parameter int DS_ES_W = 155,
  parameter int ES_MS_W = 71,
  parameter int FWD_W   = 39
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ds_to_es_valid,
  input  logic [DS_ES_W-1:0] ds_to_es_bus,
  output logic               es_allowin,
  input  logic               ms_allowin,
  output logic               es_to_ms_valid,
  output logic [ES_MS_W-1:0] es_to_ms_bus,
  output logic [FWD_W-1:0]   es_fwd_bus,
  output logic [18:0]        alu_op,
  output logic [31:0]        alu_src1,
  output logic [31:0]        alu_src2,
  input  logic [31:0]        alu_result,
  output logic               data_sram_en,
  output logic [3:0]         data_sram_we,
  output logic [31:0]        data_sram_addr,
  output logic [31:0]        data_sram_wdata
);

  logic               es_valid_q, es_valid_d;
  logic [DS_ES_W-1:0] ds_bus_q, ds_bus_d;

  logic [18:0] es_alu_op;
  logic        es_load_op;
  logic        es_mem_we;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_src1;
  logic [31:0] es_src2;
  logic [31:0] es_rkd_value;
  logic [31:0] es_pc;

  logic        es_ready_go;
  logic [31:0] es_result;

  assign {es_alu_op, es_load_op, es_mem_we, es_gr_we, es_dest,
          es_src1, es_src2, es_rkd_value, es_pc} = ds_bus_q;

  // Next state of the pipeline register: valid follows decode whenever we can accept,
  // the payload only moves when a real instruction is accepted.
  always_comb begin
    es_valid_d = es_valid_q;
    ds_bus_d   = ds_bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      ds_bus_d = ds_to_es_bus;
    end
  end

  // Decode-to-execute pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      ds_bus_q   <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      ds_bus_q   <= ds_bus_d;
    end
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {M_IDLE, M_CALC, M_DONE} mul_state_e;

  mul_state_e  mul_state_q;
  logic [63:0] prod_q;
  logic        mul_op;
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;

  assign mul_op     = |es_alu_op[14:12];
  assign mul_signed = es_alu_op[13];
  // Operands fit in 33 bits, so the low 64 bits of a 64x64 product are exact.
  assign mul_a = mul_signed ? {{32{es_src1[31]}}, es_src1} : {32'd0, es_src1};
  assign mul_b = mul_signed ? {{32{es_src2[31]}}, es_src2} : {32'd0, es_src2};

  // Multiplier sequencer: wait one cycle, register the product, then hold it until the memory stage takes it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_state_q <= M_IDLE;
      prod_q      <= '0;
    end else begin
      case (mul_state_q)
        M_IDLE: begin
          if (es_valid_q && mul_op) begin
            mul_state_q <= M_CALC;
          end
        end
        M_CALC: begin
          prod_q      <= mul_a * mul_b;
          mul_state_q <= M_DONE;
        end
        M_DONE: begin
          if (ms_allowin) begin
            mul_state_q <= M_IDLE;
          end
        end
        default: mul_state_q <= M_IDLE;
      endcase
    end
  end

  assign es_ready_go = !mul_op || (mul_state_q == M_DONE);
  assign es_result   = !mul_op       ? alu_result   :
                       es_alu_op[12] ? prod_q[31:0] : prod_q[63:32];
`else
  assign es_ready_go = 1'b1;
  assign es_result   = alu_result;
`endif

  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  assign alu_op   = es_alu_op;
  assign alu_src1 = es_src1;
  assign alu_src2 = es_src2;

  assign data_sram_en    = es_valid_q && es_ready_go && ms_allowin && (es_load_op || es_mem_we);
  assign data_sram_we    = {4{es_mem_we && data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_rkd_value;

  assign es_to_ms_bus = {es_load_op, es_gr_we, es_dest, es_result, es_pc};

  // Bypass info is driven from the register directly so decode sees it while we stall.
  assign es_fwd_bus = {es_valid_q && es_gr_we && (es_dest != 5'd0),
                       es_valid_q && es_load_op,
                       es_dest, es_result};

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized scoreboard bench for exe_stage with a behavioural ALU/multiplier reference.
module tb_exe_stage;

  logic         clk;
  logic         resetn;
  logic         ds_to_es_valid;
  logic [154:0] ds_to_es_bus;
  logic         es_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_bus;
  logic [18:0]  alu_op;
  logic [31:0]  alu_src1;
  logic [31:0]  alu_src2;
  logic [31:0]  alu_result;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  typedef struct {
    logic [70:0] ms_bus;
    logic [38:0] fwd;
    logic        mem;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  logic front_seen;
  logic ms_rand;
  logic ms_force;

  exe_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_allowin     (es_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .es_fwd_bus     (es_fwd_bus),
    .alu_op         (alu_op),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_result     (alu_result),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment ALU: add, sub, and, or, xor on bits 0..4; anything else yields 0.
  function automatic logic [31:0] alu_model(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[0]) return a + b;
    if (op[1]) return a - b;
    if (op[2]) return a & b;
    if (op[3]) return a | b;
    if (op[4]) return a ^ b;
    return 32'd0;
  endfunction

  assign alu_result = alu_model(alu_op, alu_src1, alu_src2);

  function automatic logic [31:0] ref_result(input logic [18:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EXE_MUL_EN
    int              ia, ib;
    longint          sa, sbv, sp;
    longint unsigned ua, ub, up;
    ia = a; ib = b;
    sa = ia; sbv = ib;
    ua = a;  ub = b;
    sp = sa * sbv;
    up = ua * ub;
    if (op[12]) return a * b;
    if (op[13]) return 32'(sp >>> 32);
    if (op[14]) return 32'(up >> 32);
`endif
    return alu_model(op, a, b);
  endfunction

  function automatic logic [154:0] mk(input logic [18:0] op, input logic ld, input logic st, input logic we,
                                      input logic [4:0] d, input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    return {op, ld, st, we, d, s1, s2, rkd, pc};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [154:0] rand_instr();
    logic [18:0] op;
    logic        ld, st;
    op = '0; ld = 1'b0; st = 1'b0;
    case ($urandom_range(0, 10))
      0: op[0] = 1'b1;
      1: op[1] = 1'b1;
      2: op[2] = 1'b1;
      3: op[3] = 1'b1;
      4: op[4] = 1'b1;
      5: op[12] = 1'b1;
      6: op[13] = 1'b1;
      7: op[14] = 1'b1;
      8: begin op[0] = 1'b1; ld = 1'b1; end
      9: begin op[0] = 1'b1; st = 1'b1; end
      default: op[7] = 1'b1;
    endcase
    return mk(op, ld, st, st ? 1'b0 : 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              pick(), pick(), $urandom, $urandom);
  endfunction

  task automatic chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Offer one instruction; push its expected response when the stage accepts it.
  task automatic issue(input logic [154:0] b);
    exp_t        e;
    logic [18:0] op;
    logic        ld, st, we, done;
    logic [4:0]  d;
    logic [31:0] s1, s2, rkd, pc, res;
    {op, ld, st, we, d, s1, s2, rkd, pc} = b;
    res     = ref_result(op, s1, s2);
    e.ms_bus = {ld, we, d, res, pc};
    e.fwd    = {we && (d != 5'd0), ld, d, res};
    e.mem    = ld || st;
    e.st     = st;
    e.addr   = alu_model(op, s1, s2);
    e.wdata  = rkd;
`ifdef EXE_MUL_EN
    e.lat    = (|op[14:12]) ? 3 : 1;
`else
    e.lat    = 1;
`endif
    done = 1'b0;
    @(posedge clk); #1;
    ds_to_es_bus   = b;
    ds_to_es_valid = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (es_allowin) begin
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      chk("issue_timeout", es_allowin, 1);
      ds_to_es_valid = 1'b0;
    end
  endtask

  task automatic idle();
    logic [159:0] junk;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = junk[154:0];
  endtask

  task automatic drain();
    ms_rand  = 1'b0;
    ms_force = 1'b1;
    idle();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  // Memory-stage back-pressure driver.
  initial begin
    ms_allowin = 1'b1;
    forever begin
      @(posedge clk); #1;
      ms_allowin = ms_rand ? ($urandom_range(0, 2) != 0) : ms_force;
    end
  end

  // Monitor: compares whatever the stage presents against the oldest expected entry.
  initial begin
    exp_t e;
    logic exp_en;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (data_sram_en) en_cnt++;
        if (es_to_ms_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_valid", es_to_ms_valid, 0);
          end else begin
            e = sb[0];
            chk("ms_bus", es_to_ms_bus, e.ms_bus);
            chk("fwd_bus", es_fwd_bus, e.fwd);
            if (!front_seen) begin
              chk("latency", 71'(cyc - e.acc), 71'(e.lat));
              front_seen = 1'b1;
            end
            exp_en = ms_allowin && e.mem;
            chk("sram_en", data_sram_en, exp_en);
            chk("sram_we", data_sram_we, (exp_en && e.st) ? 4'hF : 4'h0);
            if (exp_en) begin
              chk("sram_addr", data_sram_addr, e.addr);
              chk("sram_wdata", data_sram_wdata, e.wdata);
            end
            if (!ms_allowin) begin
              chk("allowin_stall", es_allowin, 0);
            end else begin
              e = sb.pop_front();
              front_seen = 1'b0;
            end
          end
        end else begin
          chk("sram_en_idle", data_sram_en, 0);
          chk("sram_we_idle", data_sram_we, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [70:0] snap;
    int          en0;
    resetn = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    ms_rand = 1'b0; ms_force = 1'b1; front_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", es_to_ms_valid, 0);
    chk("rst_allowin", es_allowin, 1);
    chk("rst_sram_en", data_sram_en, 0);
    chk("rst_sram_we", data_sram_we, 0);
    chk("rst_fwd_flags", es_fwd_bus[38:37], 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_src1", alu_src1, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);

    // Add 5 + 7
    issue(mk(19'h1, 0, 0, 1, 5'd1, 32'd5, 32'd7, 32'd0, 32'h100));
    idle();
    @(negedge clk);
    chk("add_valid", es_to_ms_valid, 1);
    chk("add_result", es_to_ms_bus[63:32], 32'd12);
    chk("add_pc", es_to_ms_bus[31:0], 32'h100);
    chk("add_allowin", es_allowin, 1);
    drain();

    // Store held two cycles, must request SRAM exactly once
    ms_force = 1'b0;
    en0 = en_cnt;
    issue(mk(19'h1, 0, 1, 0, 5'd0, 32'h1000, 32'd4, 32'hDEAD_BEEF, 32'h104));
    idle();
    repeat (2) @(negedge clk);
    ms_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("store_once", en_cnt - en0, 1);
    drain();

    // Stall an add for three cycles
    ms_force = 1'b0;
    issue(mk(19'h1, 0, 0, 1, 5'd2, 32'h10, 32'h20, 32'd0, 32'h108));
    idle();
    @(negedge clk);
    snap = es_to_ms_bus;
    chk("stall_allowin", es_allowin, 0);
    repeat (2) @(negedge clk);
    chk("stall_hold", es_to_ms_bus, snap);
    chk("stall_valid", es_to_ms_valid, 1);
    ms_force = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_once", es_to_ms_valid, 0);

    // Bypass: load to r3 stalled, then gr_we to r0 arriving as the load leaves
    ms_force = 1'b0;
    issue(mk(19'h1, 1, 0, 1, 5'd3, 32'h2000, 32'd8, 32'd0, 32'h10C));
    idle();
    @(negedge clk);
    chk("fwd_load", es_fwd_bus, {1'b1, 1'b1, 5'd3, 32'h2008});
    ms_force = 1'b1;
    issue(mk(19'h1, 0, 0, 1, 5'd0, 32'd1, 32'd2, 32'd0, 32'h110));
    ms_force = 1'b0;
    idle();
    @(negedge clk);
    chk("fwd_dest0_wr", es_fwd_bus[38], 0);
    chk("fwd_dest0_ld", es_fwd_bus[37], 0);
    drain();

    // High multiplies of 0xFFFFFFFF by 2
    issue(mk(19'h02000, 0, 0, 1, 5'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h114));
    idle();
`ifdef EXE_MUL_EN
    @(negedge clk); chk("mulh_c1", es_to_ms_valid, 0);
    @(negedge clk); chk("mulh_c2", es_to_ms_valid, 0);
    @(negedge clk); chk("mulh_c3", es_to_ms_valid, 1);
    chk("mulh_res", es_to_ms_bus[63:32], 32'hFFFF_FFFF);
    drain();
    issue(mk(19'h04000, 0, 0, 1, 5'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h118));
    idle();
    repeat (3) @(negedge clk);
    chk("mulhu_res", es_to_ms_bus[63:32], 32'h1);
`else
    @(negedge clk);
    chk("mulh_nomul_valid", es_to_ms_valid, 1);
    chk("mulh_nomul_res", es_to_ms_bus[63:32], 32'd0);
`endif
    drain();

    // Randomized traffic with random back-pressure
    ms_rand = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle();
      issue(rand_instr());
    end
    drain();

    // Reset while an instruction is mid-flight (in M_CALC when the multiplier exists)
    ms_force = 1'b0;
    issue(mk(19'h02000, 0, 0, 1, 5'd6, 32'd3, 32'd9, 32'd0, 32'h11C));
    idle();
    @(posedge clk); #1;
    resetn = 1'b0;
    sb.delete();
    front_seen = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", es_to_ms_valid, 0);
    chk("rstmid_allowin", es_allowin, 1);
    chk("rstmid_sram_en", data_sram_en, 0);
    chk("rstmid_fwd_flags", es_fwd_bus[38:37], 0);
    ms_force = 1'b1;
    issue(mk(19'h01000, 0, 0, 1, 5'd7, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'h120));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order pipeline. Sits between the decode stage and the memory stage. Holds the decode-to-execute pipeline register and drives the ALU operands from it. Issues the data-SRAM request, forwards the execute result for bypass, and hands a packed bus to the memory stage using the valid/allowin handshake. Optionally contains a two-cycle multiplier.

## Interface
Parameters:
- DS_ES_W, 155: decode-to-execute bus width.
- ES_MS_W, 71: execute-to-memory bus width.
- FWD_W, 39: bypass bus width.

Ports:
- clk  input  1  pipeline clock.
- resetn  input  1  synchronous reset, active-low.
- ds_to_es_valid  input  1  decode bus valid.
- ds_to_es_bus  input  155  {alu_op[18:0], load_op, mem_we, gr_we, dest[4:0], src1[31:0], src2[31:0], rkd_value[31:0], pc[31:0]}, MSB first.
- es_allowin  output  1  stage can accept a new instruction this cycle.
- ms_allowin  input  1  memory stage can accept.
- es_to_ms_valid  output  1  bus to memory stage valid.
- es_to_ms_bus  output  71  {res_from_mem, gr_we, dest[4:0], es_result[31:0], pc[31:0]}.
- es_fwd_bus  output  39  {es_wr_valid, es_is_load, dest[4:0], es_result[31:0]}.
- alu_op  output  19  to ALU.
- alu_src1, alu_src2  output  32 each  to ALU.
- alu_result  input  32  from ALU (combinational).
- data_sram_en  output  1  data-SRAM request.
- data_sram_we  output  4  byte write enables.
- data_sram_addr  output  32  byte address.
- data_sram_wdata  output  32  store data.

## Operation
- **Pipeline register** (es_valid plus the latched bus):
  - On es_allowin, es_valid ← ds_to_es_valid.
  - The bus is latched only when ds_to_es_valid && es_allowin; otherwise it holds.
- **Handshake:**
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
- **ALU drive:** alu_op, alu_src1 and alu_src2 come straight from the latched bus.
- **Result select:** es_result = mul_result when a mul op is active, else alu_result.
- **Memory request:**
  - data_sram_en = es_valid && es_ready_go && ms_allowin && (load_op || mem_we).
  - data_sram_we = {4{mem_we && data_sram_en}}.
  - data_sram_addr = alu_result; data_sram_wdata = rkd_value.
  - Only word access is supported. No misalignment check.
- **Memory-stage bus:** res_from_mem = load_op.
- **Bypass:**
  - es_wr_valid = es_valid && gr_we && dest != 0.
  - es_is_load = es_valid && load_op; decode stalls on it for load-use.
  - es_fwd_bus is valid even while the stage stalls.
- **Multiply ops:** alu_op[12] = mul.w (low 32), alu_op[13] = mulh.w (signed high), alu_op[14] = mulh.wu (unsigned high). At most one alu_op bit is set per instruction.
- **Multiplier FSM** (EXE_MUL_EN only): states M_IDLE, M_CALC, M_DONE.
  - M_IDLE → M_CALC when es_valid && mul op; es_ready_go = 0 in that cycle.
  - M_CALC: the 64-bit product of src1/src2 is registered (sign-extended to 33 bits for mulh.w, zero-extended otherwise). → M_DONE.
  - M_DONE: es_ready_go = 1. → M_IDLE when ms_allowin; otherwise hold, with the product register stable.

## Timing
- **Reset values** (resetn low at a clock edge):
  - es_valid = 0, latched bus = 0, mul FSM = M_IDLE, product = 0.
  - Hence es_to_ms_valid = 0, data_sram_en = 0, data_sram_we = 0, es_fwd_bus valid bits = 0, es_allowin = 1.
- **Non-mul latency:** one cycle in stage; es_ready_go = 1.
- **Mul latency:** es_ready_go asserts on the 3rd cycle in stage (cycles: IDLE, CALC, DONE).
- **Back-pressure:** with ms_allowin = 0 the latched bus and outputs hold, and no SRAM request is made. A store issues exactly once, in the cycle it leaves the stage.
- **Reset mid-mul:** the FSM returns to M_IDLE and the instruction is dropped.
- **Simultaneous events:** departure and arrival in the same cycle replace the register with no bubble.

## Configuration
- **EXE_MUL_EN defined:** multiplier and FSM are compiled in; behaviour as above.
- **EXE_MUL_EN undefined:**
  - No multiplier and no FSM; es_ready_go is tied to 1.
  - alu_op[14:12] are ignored, so es_result = alu_result for those instructions, which is 0 when no ALU bit is set.

## Test plan
- **Add:** alu_op[0], src1 = 5, src2 = 7, ms_allowin = 1 → next cycle es_to_ms_valid = 1, es_result = 12, pc passed through, es_allowin = 1.
- **Store:** mem_we = 1, src1 = 0x1000, src2 = 4, rkd = 0xDEADBEEF → a single cycle with data_sram_en = 1, we = 4'hF, addr = 0x1004, wdata = 0xDEADBEEF.
- **Stall:** ms_allowin = 0 for 3 cycles with a valid add → es_allowin = 0, outputs stable, data_sram_en = 0 throughout. Release → forwarded once.
- **mulh.w (EXE_MUL_EN):** src1 = 0xFFFFFFFF, src2 = 2 → es_to_ms_valid rises on the 3rd cycle with es_result = 0xFFFFFFFF. With mulh.wu instead → es_result = 0x00000001.
- **Reset:** resetn low during M_CALC → next cycle es_valid = 0, es_allowin = 1, FSM in M_IDLE, no output valid.
- **Bypass:** load to dest = 3 in stage → es_fwd_bus = {1, 1, 3, addr}. dest = 0 → es_wr_valid = 0.
